mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the data stage.
// Data accesses win ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ready,
    input  logic                    dm_read,
    input  logic                    dm_write,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_ready,
    input  logic                    flush,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t     state;
    logic       owner_if;
    logic       drop;
    logic [3:0] streak;

    logic dm_any;
    logic if_ok;
    logic grant_if;

    // Fetch normally yields to data; a saturated streak forces one fetch through.
    assign dm_any   = dm_read | dm_write;
    assign if_ok    = if_req & ~flush;
    assign grant_if = if_ok & (~dm_any | (streak == LIMIT));

    assign stall = (if_req & ~if_ready & ~flush) | (dm_any & ~dm_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_if  <= 1'b0;
            drop      <= 1'b0;
            streak    <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_any | if_ok) begin
                        mem_req <= 1'b1;
                        drop    <= 1'b0;
                        state   <= BUSY;
                        if (grant_if) begin
                            owner_if  <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                            streak    <= 4'd0;
                        end else begin
                            owner_if  <= 1'b0;
                            mem_we    <= dm_write;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_wstrb <= dm_write ? dm_wstrb : {STRB_WIDTH{1'b0}};
                            if (!if_req)
                                streak <= 4'd0;
                            else if (streak != LIMIT)
                                streak <= streak + 4'd1;
                        end
                    end
                end
                // A flush cannot cancel the memory transaction, only its completion pulse.
                BUSY: begin
                    if (owner_if && flush)
                        drop <= 1'b1;
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= RESP;
                        if (owner_if) begin
                            if_rdata <= mem_rdata;
                            if_ready <= ~(drop | flush);
                        end else begin
                            dm_ready <= 1'b1;
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    drop     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_read;
    logic          dm_write;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [SW-1:0] dm_wstrb;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          flush;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .flush(flush), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // The model tracks the one transaction owning the port and where it is in its life.
    typedef struct {
        bit            fetch;
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        bit            dropped;
    } txn_t;

    txn_t          txn;
    int            phase;
    int            streak;
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_dm_rdata;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic void modelReset();
        txn.fetch    = 1'b0;
        txn.write    = 1'b0;
        txn.addr     = '0;
        txn.wdata    = '0;
        txn.strb     = '0;
        txn.dropped  = 1'b0;
        phase        = 0;
        streak       = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endfunction

    function automatic void modelStep();
        bit want_dm;
        bit want_if;
        want_dm = dm_read | dm_write;
        want_if = if_req & ~flush;
        case (phase)
            0: begin
                if (want_dm || want_if) begin
                    if (want_if && (!want_dm || streak == LIMIT)) begin
                        txn.fetch = 1'b1;
                        txn.write = 1'b0;
                        txn.addr  = if_addr;
                        txn.wdata = '0;
                        txn.strb  = '0;
                        streak    = 0;
                    end else begin
                        txn.fetch = 1'b0;
                        txn.write = dm_write;
                        txn.addr  = dm_addr;
                        txn.wdata = dm_wdata;
                        txn.strb  = dm_write ? dm_wstrb : '0;
                        streak    = if_req ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
                    end
                    txn.dropped = 1'b0;
                    phase = 1;
                end
            end
            1: begin
                if (txn.fetch && flush)
                    txn.dropped = 1'b1;
                if (mem_ready) begin
                    if (txn.fetch)
                        exp_if_rdata = mem_rdata;
                    else if (!txn.write)
                        exp_dm_rdata = mem_rdata;
                    phase = 2;
                end
            end
            default: phase = 0;
        endcase
    endfunction

    task automatic compareAll();
        logic exp_ifr;
        logic exp_dmr;
        exp_ifr = (phase == 2) && txn.fetch && !txn.dropped;
        exp_dmr = (phase == 2) && !txn.fetch;
        checkOutput("mem_req", 64'(mem_req), 64'(phase == 1));
        checkOutput("mem_we", 64'(mem_we), 64'(txn.write));
        checkOutput("mem_addr", 64'(mem_addr), 64'(txn.addr));
        checkOutput("mem_wstrb", 64'(mem_wstrb), 64'(txn.strb));
        if (txn.write)
            checkOutput("mem_wdata", 64'(mem_wdata), 64'(txn.wdata));
        checkOutput("if_ready", 64'(if_ready), 64'(exp_ifr));
        checkOutput("dm_ready", 64'(dm_ready), 64'(exp_dmr));
        if (exp_ifr)
            checkOutput("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
        checkOutput("dm_rdata", 64'(dm_rdata), 64'(exp_dm_rdata));
        checkOutput("stall", 64'(stall),
                    64'((if_req & ~exp_ifr & ~flush) | ((dm_read | dm_write) & ~exp_dmr)));
    endtask

    // Inputs are set just after a rising edge; outputs are compared on the falling edge.
    task automatic runCycle();
        @(negedge clk);
        compareAll();
        @(posedge clk);
        if (rst)
            modelReset();
        else
            modelStep();
        #1;
    endtask

    task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia, input bit rd, input bit wr,
                                 input logic [AW-1:0] da, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] ws, input bit fl, input bit mr,
                                 input logic [DW-1:0] md, input int cycles);
        if_req    = ir;
        if_addr   = ia;
        dm_read   = rd;
        dm_write  = wr;
        dm_addr   = da;
        dm_wdata  = wd;
        dm_wstrb  = ws;
        flush     = fl;
        mem_ready = mr;
        mem_rdata = md;
        for (int c = 0; c < cycles; c++)
            runCycle();
    endtask

    initial begin
        rst = 1'b1;
        modelReset();
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 2);
        checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'h0);
        rst = 1'b0;

        // Lone fetch with memory always ready.
        applyStimulus(1, 32'h100, 0, 0, '0, '0, '0, 0, 1, 32'h00000013, 2);
        applyStimulus(0, 32'h100, 0, 0, '0, '0, '0, 0, 1, 32'h00000013, 2);

        // Store with three wait cycles.
        applyStimulus(0, '0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0BADF00D, 4);
        applyStimulus(0, '0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0BADF00D, 1);
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 2);

        // Continuous contention: grants cycle DM, DM, IF.
        applyStimulus(1, 32'h1000, 1, 0, 32'h3000, '0, '0, 0, 1, 32'hA5A5A5A5, 18);
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 3);

        // Flush while a fetch is in flight.
        applyStimulus(1, 32'h300, 0, 0, '0, '0, '0, 0, 0, 32'h11111111, 1);
        applyStimulus(1, 32'h300, 0, 0, '0, '0, '0, 1, 0, 32'h11111111, 1);
        applyStimulus(0, 32'h300, 0, 0, '0, '0, '0, 0, 0, 32'h11111111, 1);
        applyStimulus(0, 32'h300, 0, 0, '0, '0, '0, 0, 1, 32'h11111111, 2);
        applyStimulus(1, 32'h200, 0, 0, '0, '0, '0, 0, 1, 32'h22222222, 2);
        applyStimulus(0, 32'h200, 0, 0, '0, '0, '0, 0, 1, 32'h22222222, 2);

        // Asynchronous reset in the middle of a fetch.
        applyStimulus(1, 32'h500, 0, 0, '0, '0, '0, 0, 0, 32'h55555555, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mem_req", 64'(mem_req), 64'h0);
        checkOutput("async_rst_mem_addr", 64'(mem_addr), 64'h0);
        modelReset();
        runCycle();
        rst = 1'b0;
        applyStimulus(1, 32'h600, 1, 0, 32'h700, '0, '0, 0, 1, 32'h66666666, 9);
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 3);

        // Spurious ready while idle, then a load.
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 1, 32'hFFFFFFFF, 2);
        applyStimulus(0, '0, 1, 0, 32'h40, 32'h9999, 4'hF, 0, 1, 32'h12345678, 2);
        applyStimulus(0, '0, 0, 0, '0, '0, '0, 0, 0, '0, 2);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 32'($urandom), $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) < 2, 32'($urandom), 32'($urandom),
                          4'($urandom), $urandom_range(0, 9) < 1, $urandom_range(0, 1) == 1,
                          32'($urandom), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
